bin_dec_seq_ctrl: RTL

Sequential binary-to-decimal conversion controller for the slow decimal display path. It accepts a 14-bit binary value on a START handshake and extracts four BCD digits by repeated compare-and-subtract against the weights 1000, 100, 10 and 1, using one shared 14-bit step unit. It drives the registered digit outputs and a one-cycle VALID pulse, and sits between the CPU output register and the 7-segment/decimal display logic.

---
 rtl/bin_dec_pkg.sv | 28 ++
 rtl/bin_dec_step.sv | 20 ++
 rtl/bin_dec_seq_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/bin_dec_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller states, decimal weights and the input clamp value.
package bin_dec_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam logic [13:0] W1000   = 14'd1000;
    localparam logic [13:0] W100    = 14'd100;
    localparam logic [13:0] W10     = 14'd10;
    localparam logic [13:0] W1      = 14'd1;
    localparam logic [13:0] DEC_MAX = 14'd9999;

    function automatic logic [13:0] weight(input logic [1:0] idx);
        logic [13:0] w;
        unique case (idx)
            2'd3:    w = W1000;
            2'd2:    w = W100;
            2'd1:    w = W10;
            default: w = W1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bin_dec_step.sv
// Shared compare-and-subtract step: tests the remainder against the weight of
// the current digit position and provides the reduced remainder.
module bin_dec_step
    import bin_dec_pkg::*;
(
    input  logic [13:0] rem,
    input  logic [1:0]  idx,
    output logic        ge,
    output logic [13:0] rem_sub
);

    logic [13:0] w;

    always_comb begin
        w       = weight(idx);
        ge      = (rem >= w);
        rem_sub = rem - w;
    end

endmodule

// File: rtl/bin_dec_seq_ctrl.sv
// Sequential binary-to-decimal controller: one compare-and-subtract per CONV
// cycle, registered BCD digits and a one-cycle VALID pulse on completion.
module bin_dec_seq_ctrl
    import bin_dec_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [13:0] BIN_IN,
    output logic        BUSY,
    output logic        VALID,
    output logic        OVF,
    output logic [3:0]  DEC3,
    output logic [3:0]  DEC2,
    output logic [3:0]  DEC1,
    output logic [3:0]  DEC0
);

    state_t            state_q, state_d;
    logic [13:0]       rem_q, rem_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   wd_q, wd_d;
    logic              ovf_next_q, ovf_next_d;
    logic [3:0][3:0]   dec_q, dec_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, valid_q;
    logic              ge;
    logic [13:0]       rem_sub;

    bin_dec_step u_step (
        .rem     (rem_q),
        .idx     (idx_q),
        .ge      (ge),
        .rem_sub (rem_sub)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        ovf_next_d = ovf_next_q;
        dec_d      = dec_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            StConv: begin
                if (ge) begin
                    rem_d        = rem_sub;
                    wd_d[idx_q]  = wd_q[idx_q] + 4'd1;
                end else if (idx_q == 2'd0) begin
                    state_d = StDone;
                    dec_d   = wd_q;
                    ovf_d   = ovf_next_q;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
                if (state_q == StDone) state_d = StIdle;
                if (START) begin
                    state_d    = StConv;
                    rem_d      = (BIN_IN > DEC_MAX) ? DEC_MAX : BIN_IN;
                    ovf_next_d = (BIN_IN > DEC_MAX);
                    idx_d      = 2'd3;
                    wd_d       = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            idx_q      <= '0;
            wd_q       <= '0;
            ovf_next_q <= 1'b0;
            dec_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            ovf_next_q <= ovf_next_d;
            dec_q      <= dec_d;
            ovf_q      <= ovf_d;
            busy_q     <= (state_d == StConv);
            valid_q    <= (state_d == StDone);
        end
    end

    assign BUSY  = busy_q;
    assign VALID = valid_q;
    assign OVF   = ovf_q;
    assign DEC3  = dec_q[3];
    assign DEC2  = dec_q[2];
    assign DEC1  = dec_q[1];
    assign DEC0  = dec_q[0];

endmodule
